// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI types, default word width and CPOL/CPHA strobe mapping.
// Revision : 1.0
// ============================================================================
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    typedef struct packed {
        logic sample;
        logic setup;
    } spi_strobes_t;

    // Leading edge is rising for CPOL=0, falling for CPOL=1; CPHA selects which
    // of leading/trailing samples, the other edge launches the next bit.
    function automatic spi_strobes_t spi_strobes(
        input logic cpol,
        input logic cpha,
        input logic rise,
        input logic fall
    );
        spi_strobes_t s;
        logic         lead;
        logic         trail;
        lead     = cpol ? fall : rise;
        trail    = cpol ? rise : fall;
        s.sample = cpha ? trail : lead;
        s.setup  = cpha ? lead  : trail;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge_detect
// Brief    : Multi-flop pin synchroniser with single-cycle rise/fall strobes.
// Revision : 1.0
// ============================================================================
module spi_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // The chain and edge history keep tracking the pin through reset so that a
    // level held across reset never looks like a fresh edge afterwards.
    always_ff @(posedge i_clk) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        r_prev <= w_sync;
    end

    assign o_rise = w_sync & ~r_prev & ~i_reset;
    assign o_fall = ~w_sync & r_prev & ~i_reset;

endmodule
`default_nettype wire

// File: rtl/spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_core
// Brief    : SPI slave engine: pin sync, mode strobes, full-duplex shifting.
// Revision : 1.0
// ============================================================================
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cpol,
    input  logic                  i_cpha,
    input  logic                  i_sclk,
    input  logic                  i_ss_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic                  o_miso_oe,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_rx_overrun,
    output logic                  o_busy
);

    localparam int                 c_CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi;
    spi_strobes_t           w_strb;
    spi_state_t             r_state, w_next_state;
    logic                   w_enter, w_exit, w_active, w_word_done, w_reload, w_tx_accept;
    logic [DATA_WIDTH-1:0]  w_load_word, w_rx_next;
    logic [DATA_WIDTH-1:0]  r_tx_hold, r_tx_shift, r_rx_shift, r_rx_data;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic                   r_hold_full, r_underrun, r_skip_setup;
    logic                   r_miso, r_rx_valid, r_rx_overrun;

    spi_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_sclk),
        .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .i_clk(i_clk), .i_reset(i_reset), .i_async(i_ss_n),
        .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    always_ff @(posedge i_clk) begin
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_strb = spi_strobes(i_cpol, i_cpha, w_sclk_rise, w_sclk_fall);

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_enter      = 1'b0;
        w_exit       = 1'b0;
        case (r_state)
            IDLE:    if (w_ss_fall) begin w_next_state = ACTIVE; w_enter = 1'b1; end
            ACTIVE:  if (w_ss_rise) begin w_next_state = IDLE;   w_exit  = 1'b1; end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_active    = (r_state == ACTIVE) && !w_exit;
    assign w_word_done = w_active && w_strb.sample && (r_bit_cnt == c_LAST_BIT);
    assign w_reload    = w_enter || w_word_done;
    assign w_load_word = r_hold_full ? r_tx_hold : '1;
    assign w_rx_next   = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
    assign w_tx_accept = i_tx_valid && !r_hold_full;

    // Holding register: a write can only land while empty, so it never races
    // the reload, which drains whatever was held before this cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_hold   <= '0;
            r_hold_full <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_hold   <= i_tx_data;
            r_hold_full <= 1'b1;
        end else if (w_reload && r_hold_full) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_shift   <= '0;
            r_rx_shift   <= '0;
            r_rx_data    <= '0;
            r_bit_cnt    <= '0;
            r_underrun   <= 1'b0;
            r_skip_setup <= 1'b0;
            r_miso       <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            // CPHA=0 presents the MSB at load time; CPHA=1 waits for the first setup edge.
            if (w_reload) begin
                r_underrun <= !r_hold_full;
                if (!i_cpha) begin
                    r_tx_shift <= {w_load_word[DATA_WIDTH-2:0], 1'b0};
                    r_miso     <= w_load_word[DATA_WIDTH-1];
                end else begin
                    r_tx_shift <= w_load_word;
                end
            end
            if (w_enter) begin
                r_bit_cnt    <= '0;
                r_skip_setup <= 1'b0;
            end else if (w_exit) begin
                r_bit_cnt    <= '0;
            end else if (w_active && w_strb.sample) begin
                r_rx_shift <= w_rx_next;
                if (r_bit_cnt == c_LAST_BIT) begin
                    r_bit_cnt    <= '0;
                    r_rx_data    <= w_rx_next;
                    r_rx_valid   <= 1'b1;
                    r_rx_overrun <= r_underrun;
                    r_skip_setup <= !i_cpha;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (w_active && w_strb.setup) begin
                if (r_skip_setup) begin
                    r_skip_setup <= 1'b0;
                end else begin
                    r_miso     <= r_tx_shift[DATA_WIDTH-1];
                    r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign o_miso       = r_miso;
    assign o_miso_oe    = (r_state == ACTIVE);
    assign o_busy       = (r_state == ACTIVE);
    assign o_tx_ready   = !r_hold_full;
    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_rx_valid;
    assign o_rx_overrun = r_rx_overrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_core
// Brief    : Scoreboard bench for spi_slave_core driven by a bit-banged master.
// Revision : 1.0
// ============================================================================
module tb_spi_slave_core;

    localparam int HALF = 8;

    logic       i_clk = 1'b0;
    logic       i_reset, i_cpol, i_cpha, i_sclk, i_ss_n, i_mosi;
    logic       o_miso, o_miso_oe, o_tx_ready, o_rx_valid, o_rx_overrun, o_busy;
    logic [7:0] i_tx_data, o_rx_data;
    logic       i_tx_valid;

    always #5 i_clk = ~i_clk;

    spi_slave_core #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_cpol(i_cpol), .i_cpha(i_cpha),
        .i_sclk(i_sclk), .i_ss_n(i_ss_n), .i_mosi(i_mosi),
        .o_miso(o_miso), .o_miso_oe(o_miso_oe),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rx_overrun(o_rx_overrun),
        .o_busy(o_busy)
    );

    typedef struct {
        logic [7:0] rx;
        logic       ovr;
        logic [7:0] miso;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] miso_q[$];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rx pulse must match the oldest queued expectation.
    always @(negedge i_clk) begin
        exp_t       e;
        logic [7:0] m;
        if (!i_reset) begin
            if (o_rx_overrun && !o_rx_valid)
                check("overrun_without_valid", {31'b0, o_rx_overrun}, 32'd0);
            if (o_rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_valid", {31'b0, o_rx_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data", {24'b0, o_rx_data}, {24'b0, e.rx});
                    check("rx_overrun", {31'b0, o_rx_overrun}, {31'b0, e.ovr});
                    if (miso_q.size() == 0) begin
                        check("miso_word_missing", miso_q.size(), 32'd1);
                    end else begin
                        m = miso_q.pop_front();
                        check("miso_word", {24'b0, m}, {24'b0, e.miso});
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic write_tx(input logic [7:0] d);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        tick(1);
        i_tx_valid = 1'b0;
        check("tx_ready_after_write", {31'b0, o_tx_ready}, 32'd0);
    endtask

    task automatic push_exp(input logic [7:0] rx, input logic ovr, input logic [7:0] miso);
        exp_t e;
        e.rx   = rx;
        e.ovr  = ovr;
        e.miso = miso;
        exp_q.push_back(e);
    endtask

    // Master side: captures MISO just before each of its sample edges.
    task automatic xfer(input logic [7:0] mosi, input int nbits, input bit push);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!i_cpha) begin
                i_mosi = mosi[7-i];
                tick(HALF);
                got    = {got[6:0], o_miso};
                if (push && i == nbits - 1) miso_q.push_back(got);
                i_sclk = ~i_cpol;
                tick(HALF);
                i_sclk = i_cpol;
            end else begin
                i_sclk = ~i_cpol;
                i_mosi = mosi[7-i];
                tick(HALF);
                got    = {got[6:0], o_miso};
                if (push && i == nbits - 1) miso_q.push_back(got);
                i_sclk = i_cpol;
                tick(HALF);
            end
        end
    endtask

    task automatic select();
        i_ss_n = 1'b0;
        tick(HALF);
    endtask

    task automatic deselect();
        tick(HALF);
        i_ss_n = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},      {31'b0, o_miso},       32'd0);
        check({tag, "_miso_oe"},   {31'b0, o_miso_oe},    32'd0);
        check({tag, "_tx_ready"},  {31'b0, o_tx_ready},   32'd1);
        check({tag, "_rx_data"},   {24'b0, o_rx_data},    32'd0);
        check({tag, "_rx_valid"},  {31'b0, o_rx_valid},   32'd0);
        check({tag, "_rx_overrun"},{31'b0, o_rx_overrun}, 32'd0);
        check({tag, "_busy"},      {31'b0, o_busy},       32'd0);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha);
        i_cpol = cpol;
        i_cpha = cpha;
        i_sclk = cpol;
        tick(4);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        i_reset    = 1'b1;
        i_cpol     = 1'b0;
        i_cpha     = 1'b0;
        i_sclk     = 1'b0;
        i_ss_n     = 1'b1;
        i_mosi     = 1'b0;
        i_tx_data  = 8'h00;
        i_tx_valid = 1'b0;
        tick(5);
        check_reset_values("reset");
        i_reset = 1'b0;
        tick(2);

        // All four modes, same data
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            write_tx(8'hA5);
            push_exp(8'h3C, 1'b0, 8'hA5);
            select();
            check("busy_selected", {31'b0, o_busy}, 32'd1);
            check("oe_selected", {31'b0, o_miso_oe}, 32'd1);
            check("tx_ready_after_load", {31'b0, o_tx_ready}, 32'd1);
            xfer(8'h3C, 8, 1'b1);
            deselect();
            check("busy_released", {31'b0, o_busy}, 32'd0);
            check("oe_released", {31'b0, o_miso_oe}, 32'd0);
        end

        // Back-to-back words, second TX word written mid-transfer
        set_mode(1'b0, 1'b0);
        write_tx(8'h11);
        push_exp(8'hC3, 1'b0, 8'h11);
        push_exp(8'h5A, 1'b0, 8'h22);
        select();
        write_tx(8'h22);
        xfer(8'hC3, 8, 1'b1);
        xfer(8'h5A, 8, 1'b1);
        deselect();

        // No TX word loaded: all-ones on MISO and overrun pulse
        push_exp(8'h55, 1'b1, 8'hFF);
        select();
        xfer(8'h55, 8, 1'b1);
        deselect();

        // Abort after 5 bits, then a full word
        select();
        xfer(8'hF0, 5, 1'b0);
        deselect();
        check("busy_after_abort", {31'b0, o_busy}, 32'd0);
        check("oe_after_abort", {31'b0, o_miso_oe}, 32'd0);
        write_tx(8'h7E);
        push_exp(8'h81, 1'b0, 8'h7E);
        select();
        xfer(8'h81, 8, 1'b1);
        deselect();

        // Reset mid-word with SS_n held low
        write_tx(8'hA5);
        select();
        xfer(8'h3C, 4, 1'b0);
        i_reset = 1'b1;
        tick(1);
        check_reset_values("midreset");
        tick(1);
        i_reset = 1'b0;
        tick(2);
        xfer(8'hFF, 8, 1'b0);
        check("busy_after_reset", {31'b0, o_busy}, 32'd0);
        check("oe_after_reset", {31'b0, o_miso_oe}, 32'd0);
        deselect();
        write_tx(8'h5A);
        push_exp(8'h24, 1'b0, 8'h5A);
        select();
        xfer(8'h24, 8, 1'b1);
        deselect();

        tick(20);
        check("pending_expectations", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_core.md
# spi_slave_core

Slave-side SPI engine: the receiving end of the SCLK/MOSI/MISO/SS_n link driven by the team's master clock generator and shifter. It synchronises the external SPI pins into the system clock domain, detects SCLK edges, derives sample/setup strobes from CPOL/CPHA, and shifts full-duplex words through a one-deep TX holding register and an RX output register. It sits between the SPI pads and the register/AXI side of a slave peripheral.

## Interface
- DATA_WIDTH, 8, bits per SPI word
- SYNC_STAGES, 2, flops in each pin synchroniser (minimum 2)
- i_clk  in  1  system clock, 10-200 MHz; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cpol  in  1  SCLK idle level; static while i_ss_n is low
- i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- i_sclk  in  1  asynchronous SPI clock from master
- i_ss_n  in  1  asynchronous slave select, active low
- i_mosi  in  1  asynchronous master-out data
- o_miso  out  1  slave-out data, MSB first
- o_miso_oe  out  1  MISO output enable; high only while selected
- i_tx_data  in  DATA_WIDTH  next word to transmit
- i_tx_valid  in  1  i_tx_data valid; accepted when o_tx_ready high
- o_tx_ready  out  1  TX holding register empty
- o_rx_data  out  DATA_WIDTH  last complete received word
- o_rx_valid  out  1  one-cycle pulse, o_rx_data updated
- o_rx_overrun  out  1  one-cycle pulse, word completed with no TX word loaded (underrun of TX holding)
- o_busy  out  1  high while selected (synchronised SS_n low)

## Operation
- Pins pass through SYNC_STAGES flops; one extra registered copy of synced SCLK gives rising/falling strobes. Leading edge = rising if i_cpol=0, falling if 1; trailing = the other.
- sample strobe = leading if i_cpha=0, trailing if i_cpha=1; setup strobe = the other edge.
- States: IDLE, ACTIVE. IDLE -> ACTIVE on synced SS_n falling; ACTIVE -> IDLE on synced SS_n rising (any bit count).
- On entry to ACTIVE: bit counter = 0; TX shift register loaded from holding register if full (holding cleared, o_tx_ready=1), else loaded with all-ones and underrun flag set for this word. CPHA=0: o_miso = MSB immediately. CPHA=1: o_miso updated on first setup edge.
- Sample strobe: RX shift <= {RX shift[DATA_WIDTH-2:0], synced MOSI}; counter++. At counter = DATA_WIDTH-1 -> word complete: o_rx_data <= new word, o_rx_valid pulse, o_rx_overrun pulse if underrun flag set; counter wraps to 0; TX shift reloaded as on entry.
- Setup strobe: o_miso <= next TX bit. For CPHA=0, the setup edge after the last sample of a word is ignored for shifting (new MSB already presented by the reload).
- SS_n rising mid-word: partial RX discarded, no o_rx_valid, counter cleared, TX shift contents discarded; holding register untouched.
- TX write: i_tx_valid && o_tx_ready loads holding, o_tx_ready=0 next cycle. Write and reload in the same cycle: reload takes old holding content (or all-ones if empty); new word stays in holding.
- SCLK edges while IDLE ignored.

## Timing
- Reset values: o_miso=0, o_miso_oe=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_rx_overrun=0, o_busy=0; state IDLE.
- Pin-to-strobe latency: SYNC_STAGES+1 i_clk cycles.
- o_rx_valid asserted the cycle after the final sample strobe.
- o_miso changes the cycle after the setup strobe; o_miso_oe/o_busy follow synced SS_n with SYNC_STAGES+1 latency.
- Requirement: each SCLK high and low phase >= SYNC_STAGES+2 i_clk cycles; SS_n setup before first SCLK edge >= same.
- Reset mid-transfer wins over all events; returns to IDLE regardless of SS_n level, re-entering ACTIVE only on next SS_n falling.

## Structure
- spi_pkg: state enum (IDLE, ACTIVE), DATA_WIDTH default, function mapping (cpol, cpha, rise, fall) to sample/setup strobes; shared with the master shifter.
- Sub-module spi_sync_edge_detect: SYNC_STAGES synchroniser plus rise/fall strobe generation, instantiated for SCLK and SS_n; MOSI uses synchroniser only.

## Test plan
- Mode 0, tx 0xA5 preloaded, master sends 0x3C -> o_rx_data=0x3C with one o_rx_valid pulse, MISO bits 1,0,1,0,0,1,0,1.
- Modes 1, 2, 3 each, same data -> identical results; MISO changes only on setup edges.
- Two back-to-back words, tx 0x11 then 0x22 written during first word -> rx pulses twice, MISO 0x11 then 0x22, no overrun.
- No TX word loaded, master sends 0x55 -> MISO all ones, o_rx_overrun pulse with o_rx_valid, o_rx_data=0x55.
- SS_n released after 5 bits -> no o_rx_valid, o_busy/o_miso_oe drop; next full word 0x81 received correctly.
- i_reset asserted mid-word -> all outputs at reset values next cycle; no rx pulse until a fresh SS_n falling edge.
